conv_enc_scheduler: RTL
=======================

CONV_ENC_SCHEDULER -- requirements
Module: conv_enc_scheduler

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req  input  2  per-requester encode request, level, held until grant.
REQ-004 len_sel  input  2  per-requester block length: 0 = 1056 bits (132 bytes), 1 = 6144 bits (768 bytes).
REQ-005 tail0, tail1  input  8 each  per-requester tail byte (last 8 input bits, tail-biting init).
REQ-006 grant  output  2  one-hot owner of the encoder, held from launch until release.
REQ-007 enc_data_valid  output  1  one-cycle start pulse to the encoder.
REQ-008 enc_code_block_length  output  1  len_sel of the owner, stable while grant != 0.
REQ-009 enc_tail_byte  output  8  tail byte of the owner, stable while grant != 0.
REQ-010 enc_computation_done  input  1  encoder done level.
REQ-011 enc_rdreq  output  1  read strobe to the three subblock FIFOs, driven in common.
REQ-012 out_ready  input  1  downstream may accept a beat one cycle later.
REQ-013 out_valid, out_last  output  1 each  beat valid; final beat of the block.
REQ-014 out_owner  output  1  requester index of the current beat.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 err  output  1  sticky watchdog error (REQ-031).

Function
REQ-017 States: IDLE, LAUNCH, ENCODE, DRAIN, RELEASE; 3-bit encoding.
REQ-018 IDLE: when req != 0, grant via round-robin; the requester not served last wins ties; latch owner, length and tail; go to LAUNCH.
REQ-019 Round-robin pointer reset value: requester 0 wins the first tie.
REQ-020 LAUNCH: enc_data_valid = 1 for exactly this cycle; go to ENCODE.
REQ-021 ENCODE: wait for a 0->1 edge of enc_computation_done; a level already high on entry is ignored; go to DRAIN.
REQ-022 DRAIN: byte counter loaded with 132 or 768 on entry; enc_rdreq = out_ready && count != 0; count decrements on each enc_rdreq.
REQ-023 out_valid is enc_rdreq delayed one cycle (FIFO read latency 1); out_last accompanies the beat for the rdreq issued with count == 1.
REQ-024 DRAIN exits to RELEASE the cycle after the final out_valid.
REQ-025 RELEASE: one cycle; grant returns to 0; pointer updated to owner; go to IDLE. A new grant is at least two cycles after out_last.
REQ-026 req changes while granted are ignored; the owner's req is not required to stay high after grant.
REQ-027 out_ready low stalls enc_rdreq only; an out_valid already in flight is still emitted.
REQ-028 Total enc_rdreq pulses per block equal 132 or 768 exactly; never more.

Reset
REQ-029 On reset: state IDLE, grant 0, all pulses 0, counter 0, pointer to requester 0, err 0, out_owner 0.
REQ-030 Reset mid-block aborts immediately with no further enc_rdreq or out_valid; FIFO content is not flushed by this block.

Configuration
REQ-031 CONV_SCHED_WATCHDOG_EN defined: 14-bit cycle counter runs in ENCODE; at 12000 cycles without done, set err and go to RELEASE (no drain). Undefined: no counter, err tied 0, ENCODE waits indefinitely.

Verification
REQ-032 req=01, len_sel=0, tail0=8'hA5, done edge 1060 cycles after launch, out_ready=1 -> one enc_data_valid pulse, tail 8'hA5, 132 beats, out_last on beat 132, owner 0.
REQ-033 req=11 held for three blocks -> grants in order 0,1,0; each grant one-hot, gaps >= 2 cycles.
REQ-034 len_sel=1, out_ready toggled 1,0 every cycle -> exactly 768 beats, no beat without a preceding rdreq.
REQ-035 done already high on ENCODE entry, edge 20 cycles later -> drain starts only after the edge.
REQ-036 reset asserted at beat 50 of 132 -> next cycle all outputs at reset values, no further beats.
REQ-037 With CONV_SCHED_WATCHDOG_EN, done never asserted -> err=1 at cycle 12000 of ENCODE, grant cleared, zero beats; without the macro, err stays 0.

Source files
------------

// File: rtl/conv_enc_scheduler.sv
// rtl/conv_enc_scheduler.sv - round-robin owner scheduler and FIFO drain sequencer for a shared convolutional encoder
// Optional encode watchdog: define CONV_SCHED_WATCHDOG_EN.

module conv_enc_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic [1:0] len_sel_i,
    input  logic [7:0] tail0_i,
    input  logic [7:0] tail1_i,
    output logic [1:0] grant_o,
    output logic       enc_data_valid_o,
    output logic       enc_code_block_length_o,
    output logic [7:0] enc_tail_byte_o,
    input  logic       enc_computation_done_i,
    output logic       enc_rdreq_o,
    input  logic       out_ready_i,
    output logic       out_valid_o,
    output logic       out_last_o,
    output logic       out_owner_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_ENCODE  = 3'd2,
        S_DRAIN   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [9:0] LEN_SHORT = 10'd132;
    localparam logic [9:0] LEN_LONG  = 10'd768;

    state_t     state_q;
    logic [1:0] grant_q;
    logic       owner_q;
    logic       len_q;
    logic [7:0] tail_q;
    logic       prio_q;
    logic [9:0] count_q;
    logic       done_prev_q;
    logic       dv_q;
    logic       valid_q;
    logic       last_q;
    logic       out_owner_q;

    logic       rdreq_d;
    logic       done_edge_d;
    logic       winner_d;

`ifdef CONV_SCHED_WATCHDOG_EN
    localparam logic [13:0] WD_LIMIT = 14'd11999;
    logic [13:0] wd_q;
    logic        err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Reset gates the strobe in its own cycle so an abort issues no further FIFO reads.
    always_comb begin
        rdreq_d     = (state_q == S_DRAIN) && out_ready_i && (count_q != 10'd0) && !reset;
        done_edge_d = enc_computation_done_i && !done_prev_q;
        winner_d    = (req_i == 2'b11) ? prio_q : req_i[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            owner_q     <= 1'b0;
            len_q       <= 1'b0;
            tail_q      <= 8'h00;
            prio_q      <= 1'b0;
            count_q     <= 10'd0;
            done_prev_q <= 1'b0;
            dv_q        <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            out_owner_q <= 1'b0;
`ifdef CONV_SCHED_WATCHDOG_EN
            wd_q        <= 14'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            done_prev_q <= enc_computation_done_i;
            dv_q        <= 1'b0;
            valid_q     <= rdreq_d;
            last_q      <= rdreq_d && (count_q == 10'd1);
            if (rdreq_d) begin
                count_q     <= count_q - 10'd1;
                out_owner_q <= owner_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (req_i != 2'b00) begin
                        owner_q <= winner_d;
                        grant_q <= winner_d ? 2'b10 : 2'b01;
                        len_q   <= len_sel_i[winner_d];
                        tail_q  <= winner_d ? tail1_i : tail0_i;
                        dv_q    <= 1'b1;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
`ifdef CONV_SCHED_WATCHDOG_EN
                    wd_q    <= 14'd0;
`endif
                    state_q <= S_ENCODE;
                end
                S_ENCODE: begin
                    if (done_edge_d) begin
                        count_q <= len_q ? LEN_LONG : LEN_SHORT;
                        state_q <= S_DRAIN;
                    end
`ifdef CONV_SCHED_WATCHDOG_EN
                    else if (wd_q == WD_LIMIT) begin
                        err_q   <= 1'b1;
                        grant_q <= 2'b00;
                        state_q <= S_RELEASE;
                    end else begin
                        wd_q <= wd_q + 14'd1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (valid_q && last_q) begin
                        grant_q <= 2'b00;
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // The requester just served loses the next tie.
                    prio_q  <= ~owner_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant_o                 = grant_q;
    assign enc_data_valid_o        = dv_q;
    assign enc_code_block_length_o = len_q;
    assign enc_tail_byte_o         = tail_q;
    assign enc_rdreq_o             = rdreq_d;
    assign out_valid_o             = valid_q;
    assign out_last_o              = last_q;
    assign out_owner_o             = out_owner_q;
    assign busy_o                  = (state_q != S_IDLE);

endmodule
